// File: rtl/rvv_backend_vrf_read_responder_pkg.sv
// rvv_backend_vrf_read_responder_pkg: shared sizes and operand-buffer entry type for the VRF read responder
package rvv_backend_vrf_read_responder_pkg;
    localparam int NUM_PORT = 4;
    localparam int IDX_W = 5;
    localparam int DATA_W = 128;
    localparam int NUM_WB = 2;
    localparam int VRF_RD_BUF_DEPTH = 2;
    typedef struct packed {
        logic [NUM_PORT-1:0]             en;
        logic [NUM_PORT-1:0][DATA_W-1:0] data;
    } vrf_rd_entry_t;
endpackage

// File: rtl/rvv_backend_vrf_read_responder_fifo.sv
// rvv_backend_vrf_read_responder_fifo: DEPTH-entry operand group FIFO with flush, full and empty
module rvv_backend_vrf_read_responder_fifo
    import rvv_backend_vrf_read_responder_pkg::*;
#(
    parameter int DEPTH = VRF_RD_BUF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  vrf_rd_entry_t wdata,
    output vrf_rd_entry_t rdata,
    output logic          full,
    output logic          empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    vrf_rd_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & ~full & ~flush;
    assign do_pop = pop & ~empty & ~flush;
    assign rdata = mem[rd_ptr];
    // flush resets occupancy only; stale entry data is never observable once count is 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rvv_backend_vrf_read_responder.sv
// rvv_backend_vrf_read_responder: drives VRF read addresses and buffers operand groups; RVV_VRF_RD_BYPASS_EN adds writeback forwarding
module rvv_backend_vrf_read_responder
    import rvv_backend_vrf_read_responder_pkg::*;
#(
    parameter int DEPTH = VRF_RD_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NUM_PORT-1:0]        req_en,
    input  logic [NUM_PORT*IDX_W-1:0]  req_index,
    output logic [NUM_PORT*IDX_W-1:0]  vrf_rd_index,
    input  logic [NUM_PORT*DATA_W-1:0] vrf_rd_data,
`ifdef RVV_VRF_RD_BYPASS_EN
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]    wb_index,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data,
`endif
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [NUM_PORT-1:0]        rsp_en,
    output logic [NUM_PORT*DATA_W-1:0] rsp_data
);
    vrf_rd_entry_t wdata, rdata;
    logic full, empty;
    assign vrf_rd_index = req_index;
    // disabled ports store zero; later matching wb ports override earlier ones
    always_comb begin
        wdata.en = req_en;
        for (int p = 0; p < NUM_PORT; p++) begin
            wdata.data[p] = req_en[p] ? vrf_rd_data[p*DATA_W +: DATA_W] : '0;
`ifdef RVV_VRF_RD_BYPASS_EN
            for (int w = 0; w < NUM_WB; w++)
                if (req_en[p] && wb_valid[w] && wb_index[w*IDX_W +: IDX_W] == req_index[p*IDX_W +: IDX_W])
                    wdata.data[p] = wb_data[w*DATA_W +: DATA_W];
`endif
        end
    end
    rvv_backend_vrf_read_responder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push(req_valid),
        .pop(rsp_ready),
        .wdata(wdata),
        .rdata(rdata),
        .full(full),
        .empty(empty)
    );
    assign req_ready = ~full;
    assign rsp_valid = ~empty;
    assign rsp_en = rdata.en;
    assign rsp_data = rdata.data;
endmodule
